// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Ports: clk_i/rst_i (sync, active-high); load_i latches value_i, dp_i
//   and lzb_i; seg7_o (active-low a..g,dp), an_o (active-low digit
//   enables) and frame_o (pulse at the start of the digit-0 slot).
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_CYCLES   = 1000,
  parameter int GUARD_CYCLES = 1,
  parameter int HEX_EN       = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    lzb_i,
  output logic [7:0]              seg7_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  // One extra bit so DIV_CYCLES itself fits when GUARD_CYCLES is 0.
  localparam logic [CW:0] GSTART =
    (CW+1)'(DIV_CYCLES - GUARD_CYCLES);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic                    lzb_q, lzb_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;

  logic [3:0] nib;
  logic       dp_bit;
  logic       blank;
  logic       guard;
  logic [6:0] code;

  always_comb begin
    value_d = load_i ? value_i : value_q;
    dp_d    = load_i ? dp_i : dp_q;
    lzb_d   = load_i ? lzb_i : lzb_q;

    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST)
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  always_comb begin
    nib    = 4'h0;
    dp_bit = 1'b0;
    // Blank while every digit from idx upward is zero; never digit 0.
    blank  = lzb_q && (idx_q != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib    = value_q[4*k +: 4];
        dp_bit = dp_q[k];
      end
      if (IW'(k) >= idx_q && value_q[4*k +: 4] != 4'h0)
        blank = 1'b0;
    end
  end

  always_comb begin
    code = 7'h40;
    case (nib)
      4'h0: code = 7'h3F;
      4'h1: code = 7'h06;
      4'h2: code = 7'h5B;
      4'h3: code = 7'h4F;
      4'h4: code = 7'h66;
      4'h5: code = 7'h6D;
      4'h6: code = 7'h7D;
      4'h7: code = 7'h07;
      4'h8: code = 7'h7F;
      4'h9: code = 7'h6F;
      4'hA: code = (HEX_EN != 0) ? 7'h77 : 7'h40;
      4'hB: code = (HEX_EN != 0) ? 7'h7C : 7'h40;
      4'hC: code = (HEX_EN != 0) ? 7'h39 : 7'h40;
      4'hD: code = (HEX_EN != 0) ? 7'h5E : 7'h40;
      4'hE: code = (HEX_EN != 0) ? 7'h79 : 7'h40;
      default: code = (HEX_EN != 0) ? 7'h71 : 7'h40;
    endcase
  end

  always_comb begin
    guard   = ({1'b0, cnt_q} >= GSTART);
    frame_d = (cnt_q == '0) && (idx_q == '0);
    seg_d   = 8'hFF;
    an_d    = {NUM_DIGITS{1'b1}};
    if (!guard) begin
      if (blank) begin
        if (dp_bit) begin
          an_d  = ~(NUM_DIGITS'(1) << idx_q);
          seg_d = 8'h7F;
        end
      end else begin
        an_d  = ~(NUM_DIGITS'(1) << idx_q);
        seg_d = ~{dp_bit, code};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      value_q <= '0;
      dp_q    <= '0;
      lzb_q   <= 1'b0;
      seg_q   <= 8'hFF;
      an_q    <= {NUM_DIGITS{1'b1}};
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      dp_q    <= dp_d;
      lzb_q   <= lzb_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign seg7_o  = seg_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 8-cycle slots, 2 guard
// cycles; a second instance with HEX_EN=1 shares the same stimulus.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        load_i;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic        lzb_i;
  logic [7:0]  seg7_o, seg7_h;
  logic [3:0]  an_o, an_h;
  logic        frame_o, frame_h;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .DIV_CYCLES(8), .GUARD_CYCLES(2), .HEX_EN(0)
  ) u_dut (
    .clk_i(clk), .rst_i(rst_i), .load_i(load_i),
    .value_i(value_i), .dp_i(dp_i), .lzb_i(lzb_i),
    .seg7_o(seg7_o), .an_o(an_o), .frame_o(frame_o)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(4), .DIV_CYCLES(8), .GUARD_CYCLES(2), .HEX_EN(1)
  ) u_hex (
    .clk_i(clk), .rst_i(rst_i), .load_i(load_i),
    .value_i(value_i), .dp_i(dp_i), .lzb_i(lzb_i),
    .seg7_o(seg7_h), .an_o(an_h), .frame_o(frame_h)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] sg[4];
  logic [7:0] sh[4];
  logic [3:0] an[4];

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(logic [15:0] v, logic [3:0] dp, logic lz);
    value_i = v;
    dp_i    = dp;
    lzb_i   = lz;
    load_i  = 1'b1;
    tick();
    load_i  = 1'b0;
    tick();
  endtask

  task automatic wait_frame();
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      found = frame_o;
    end
    if (!found) check("frame_timeout", 0, 1);
  endtask

  task automatic grab();
    wait_frame();
    for (int k = 0; k < 4; k++) begin
      sg[k] = seg7_o;
      sh[k] = seg7_h;
      an[k] = an_o;
      if (k < 3) tick(8);
    end
  endtask

  initial begin
    int bad;
    logic [3:0] ea;
    logic [7:0] es;
    rst_i = 1'b1; load_i = 1'b0;
    value_i = '0; dp_i = '0; lzb_i = 1'b0;
    tick(2);
    check("rst_seg", seg7_o, 8'hFF);
    check("rst_an", an_o, 4'hF);
    check("rst_frame", frame_o, 1'b0);

    rst_i = 1'b0;
    tick();
    check("first_frame", frame_o, 1'b1);
    check("first_seg", seg7_o, 8'hC0);
    check("first_an", an_o, 4'hE);

    bad = 0;
    for (int o = 1; o < 32; o++) begin
      tick();
      if (o % 8 >= 6) begin
        ea = 4'hF; es = 8'hFF;
      end else begin
        ea = ~(4'b0001 << (o / 8)); es = 8'hC0;
      end
      if (an_o !== ea || seg7_o !== es || frame_o !== 1'b0) bad++;
    end
    check("scan_pattern", bad, 0);
    tick();
    check("frame_period", frame_o, 1'b1);

    load(16'h1234, 4'b0000, 1'b0);
    grab();
    check("s2_seg", {sg[3], sg[2], sg[1], sg[0]}, 32'hF9A4B099);
    check("s2_an", {an[3], an[2], an[1], an[0]}, 16'h7BDE);

    load(16'h0050, 4'b0000, 1'b1);
    grab();
    check("s3a_seg", {sg[3], sg[2], sg[1], sg[0]}, 32'hFFFF92C0);
    check("s3a_an", {an[3], an[2], an[1], an[0]}, 16'hFFDE);

    load(16'h0000, 4'b0000, 1'b1);
    grab();
    check("s3b_seg", {sg[3], sg[2], sg[1], sg[0]}, 32'hFFFFFFC0);
    check("s3b_an", {an[3], an[2], an[1], an[0]}, 16'hFFFE);

    load(16'h00AF, 4'b0000, 1'b0);
    grab();
    check("s4_dash", {sg[3], sg[2], sg[1], sg[0]}, 32'hC0C0BFBF);
    check("s4_hex", {sh[3], sh[2], sh[1], sh[0]}, 32'hC0C0888E);

    load(16'h1234, 4'b0100, 1'b0);
    grab();
    check("s5a_dp", sg[2], 8'h24);

    load(16'h0000, 4'b1000, 1'b1);
    grab();
    check("s5b_seg", {sg[3], sg[2], sg[1], sg[0]}, 32'h7FFFFFC0);
    check("s5b_an", {an[3], an[2], an[1], an[0]}, 16'h7FFE);

    load(16'h0000, 4'b0000, 1'b0);
    wait_frame();
    tick(2);
    check("s6_before", seg7_o, 8'hC0);
    value_i = 16'h9999;
    load_i  = 1'b1;
    tick();
    load_i  = 1'b0;
    check("s6_load_edge", seg7_o, 8'hC0);
    tick();
    check("s6_after", seg7_o, 8'h90);
    check("s6_an", an_o, 4'hE);

    tick(14);
    check("s6_digit2", an_o, 4'hB);
    rst_i   = 1'b1;
    load_i  = 1'b1;
    value_i = 16'h8888;
    tick();
    rst_i  = 1'b0;
    load_i = 1'b0;
    check("midrst_seg", seg7_o, 8'hFF);
    check("midrst_an", an_o, 4'hF);
    check("midrst_frame", frame_o, 1'b0);
    tick();
    check("postrst_frame", frame_o, 1'b1);
    check("postrst_seg", seg7_o, 8'hC0);
    tick(8);
    check("postrst_d1", seg7_o, 8'hC0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
